// File: rtl/motor_pkg.sv
// motor_pkg: shared types and constants for the motor pulse-width scheduler and PWM generator
package motor_pkg;
  localparam int DEF_PW_W = 20;
  localparam int DEF_PW_MIN = 17500;
  localparam int DEF_PW_MAX = 95616;
  localparam int DEF_PW_NEUTRAL = 56558;
  localparam int PWM_PERIOD = 500000;
  typedef enum logic [2:0] {ST_IDLE, ST_MANUAL, ST_JOG, ST_CAMERA, ST_TIMEOUT} state_t;
  localparam logic [3:0] STAT_IDLE = 4'd0;
  localparam logic [3:0] STAT_MANUAL = 4'd1;
  localparam logic [3:0] STAT_CAMERA = 4'd2;
  localparam logic [3:0] STAT_JOG = 4'd3;
  localparam logic [3:0] STAT_TIMEOUT = 4'd4;
  localparam logic [1:0] SW_CAMERA = 2'b00;
  localparam logic [1:0] SW_MAX = 2'b01;
  localparam logic [1:0] SW_MIN = 2'b10;
  localparam logic [1:0] SW_JOG = 2'b11;
  function automatic logic [3:0] status_of(state_t s);
    return s == ST_MANUAL ? STAT_MANUAL : s == ST_CAMERA ? STAT_CAMERA :
           s == ST_JOG ? STAT_JOG : s == ST_TIMEOUT ? STAT_TIMEOUT : STAT_IDLE;
  endfunction
  function automatic state_t mode_of(logic [1:0] sw);
    return sw == SW_CAMERA ? ST_CAMERA : sw == SW_JOG ? ST_JOG : ST_MANUAL;
  endfunction
endpackage

// File: rtl/motor_pw_slew.sv
// motor_pw_slew: holds target and pw_out, clamps target writes and slews pw_out once per PWM period
module motor_pw_slew #(
  parameter int PW_W = 20,
  parameter int PW_MIN = 17500,
  parameter int PW_MAX = 95616,
  parameter int PW_NEUTRAL = 56558,
  parameter int SLEW_STEP = 128
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic            period_start,
  input  logic            target_we,
  input  logic [PW_W-1:0] target_in,
  output logic [PW_W-1:0] pw_out,
  output logic [PW_W-1:0] target,
  output logic            pw_load,
  output logic            busy
);
  localparam logic [PW_W-1:0] MIN = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] MAX = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] NEU = PW_W'(PW_NEUTRAL);
  localparam logic [PW_W-1:0] STEP = PW_W'(SLEW_STEP);
  logic [PW_W-1:0] clamped, stepped;
  always_comb begin
    clamped = target_in < MIN ? MIN : target_in > MAX ? MAX : target_in;
    stepped = target > pw_out ? (target - pw_out <= STEP ? target : pw_out + STEP)
                              : (pw_out - target <= STEP ? target : pw_out - STEP);
  end
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      pw_out <= NEU;
      target <= NEU;
      pw_load <= 1'b0;
    end else begin
      pw_load <= period_start;
      if (period_start) pw_out <= stepped;
      if (target_we) target <= clamped;
    end
  end
  assign busy = pw_out != target;
endmodule

// File: rtl/motor_pw_sched.sv
// motor_pw_sched: arbitrates camera/manual/jog pulse-width sources and feeds the slew stage
module motor_pw_sched import motor_pkg::*; #(
  parameter int PW_W = DEF_PW_W,
  parameter int PW_MIN = DEF_PW_MIN,
  parameter int PW_MAX = DEF_PW_MAX,
  parameter int PW_NEUTRAL = DEF_PW_NEUTRAL,
  parameter int SLEW_STEP = 128,
  parameter int JOG_STEP = 128,
  parameter int TIMEOUT_PER = 50
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic [1:0]      sw,
  input  logic            push,
  input  logic            period_start,
  input  logic            cam_req,
  input  logic [PW_W-1:0] cam_pw,
  output logic            cam_ack,
  output logic [PW_W-1:0] pw_out,
  output logic            pw_load,
  output logic [PW_W-1:0] target,
  output logic [3:0]      status,
  output logic            busy
);
  localparam int WD_W = $clog2(TIMEOUT_PER + 1);
  localparam logic [PW_W-1:0] MIN = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] MAX = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] NEU = PW_W'(PW_NEUTRAL);
  localparam logic [PW_W-1:0] JSTEP = PW_W'(JOG_STEP);
  localparam logic [PW_W-1:0] JOG_WRAP = PW_W'(PW_MAX - JOG_STEP);
  state_t state, nxt, sw_mode;
  logic [WD_W-1:0] wd;
  logic [PW_W-1:0] jog, tgt_in;
  logic [1:0] sync;
  logic push_q, fall, cam_mode, acc, wd_hit, tgt_we;
  assign sw_mode = mode_of(sw);
  assign cam_mode = state == ST_CAMERA || state == ST_TIMEOUT;
  // a pending sw change blocks the accept, so a mode change always wins over a request
  assign acc = cam_mode && sw == SW_CAMERA && cam_req && !cam_ack;
  assign wd_hit = state == ST_CAMERA && period_start && wd == WD_W'(TIMEOUT_PER - 1);
  assign fall = push_q & ~sync[1];
  always_comb begin
    nxt = state;
    if (state == ST_IDLE) nxt = period_start ? sw_mode : ST_IDLE;
    else if (sw_mode != ST_CAMERA) nxt = sw_mode;
    else if (!cam_mode || acc) nxt = ST_CAMERA;
    else if (wd_hit) nxt = ST_TIMEOUT;
    tgt_we = nxt == ST_MANUAL || nxt == ST_JOG || acc || (nxt == ST_TIMEOUT && state != ST_TIMEOUT);
    tgt_in = nxt == ST_MANUAL ? (sw == SW_MAX ? MAX : MIN) : nxt == ST_JOG ? jog : acc ? cam_pw : NEU;
  end
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state <= ST_IDLE;
      cam_ack <= 1'b0;
      wd <= '0;
      jog <= NEU;
      sync <= 2'b11;
      push_q <= 1'b1;
    end else begin
      state <= nxt;
      cam_ack <= acc;
      sync <= {sync[0], push};
      push_q <= sync[1];
      wd <= (nxt != ST_CAMERA || acc) ? '0 : period_start ? wd + 1'b1 : wd;
      if (state == ST_JOG && fall) jog <= jog > JOG_WRAP ? MIN : jog + JSTEP;
    end
  end
  assign status = status_of(state);
  motor_pw_slew #(
    .PW_W(PW_W), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_NEUTRAL(PW_NEUTRAL), .SLEW_STEP(SLEW_STEP)
  ) u_slew (
    .m_clock(m_clock),
    .p_reset(p_reset),
    .period_start(period_start),
    .target_we(tgt_we),
    .target_in(tgt_in),
    .pw_out(pw_out),
    .target(target),
    .pw_load(pw_load),
    .busy(busy)
  );
endmodule

// File: tb/tb_motor_pw_sched.sv
// tb_motor_pw_sched: directed stimulus with load/ack scoreboards checked by a negedge monitor
module tb_motor_pw_sched;
  localparam logic [19:0] MIN = 20'd17500;
  localparam logic [19:0] MAX = 20'd95616;
  localparam logic [19:0] NEU = 20'd56558;
  localparam logic [19:0] STEP = 20'd128;
  logic m_clock = 1'b0;
  logic p_reset, push, period_start, cam_req, cam_ack, pw_load, busy;
  logic [1:0] sw;
  logic [19:0] cam_pw, pw_out, target;
  logic [3:0] status;
  int checks = 0;
  int failures = 0;
  logic [19:0] load_q[$];
  logic [19:0] ack_q[$];
  logic [19:0] pw_m, tgt_m, jm;

  motor_pw_sched dut (
    .m_clock(m_clock), .p_reset(p_reset), .sw(sw), .push(push), .period_start(period_start),
    .cam_req(cam_req), .cam_pw(cam_pw), .cam_ack(cam_ack), .pw_out(pw_out), .pw_load(pw_load),
    .target(target), .status(status), .busy(busy)
  );

  always #5 m_clock = ~m_clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [19:0] step(logic [19:0] p, logic [19:0] t);
    if (t > p) return (t - p <= STEP) ? t : p + STEP;
    return (p - t <= STEP) ? t : p - STEP;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge m_clock);
      #1;
    end
  endtask

  task automatic strobe(int gap);
    period_start = 1'b1;
    pw_m = step(pw_m, tgt_m);
    load_q.push_back(pw_m);
    tick();
    period_start = 1'b0;
    tick(gap);
  endtask

  always @(negedge m_clock) begin
    if (pw_load) begin
      if (load_q.size() == 0) flag("unexpected_load");
      else chk("load_pw_out", pw_out, load_q.pop_front());
    end
    if (cam_ack) begin
      if (ack_q.size() == 0) flag("unexpected_ack");
      else begin
        chk("ack_target", target, ack_q.pop_front());
        chk("ack_status", status, 4'd2);
      end
    end
  end

  initial begin
    p_reset = 1'b1; sw = 2'b01; push = 1'b1; period_start = 1'b0; cam_req = 1'b0; cam_pw = '0;
    pw_m = NEU; tgt_m = NEU;
    tick(3);
    p_reset = 1'b0;
    chk("rst_pw_out", pw_out, NEU);
    chk("rst_target", target, NEU);
    chk("rst_status", status, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", cam_ack, 1'b0);
    tick(5);
    // manual max: first strobe leaves IDLE, then slew all the way up
    strobe(19);
    tgt_m = MAX;
    chk("manual_status", status, 4'd1);
    chk("manual_target", target, MAX);
    for (int i = 0; i < 400 && pw_m != MAX; i++) strobe(19);
    chk("manual_pw_out", pw_out, MAX);
    chk("manual_busy", busy, 1'b0);
    // camera: clamp high, then clamp low with a held request yielding two acks
    sw = 2'b00;
    tick(2);
    chk("cam_status", status, 4'd2);
    cam_req = 1'b1; cam_pw = 20'd200000; ack_q.push_back(MAX);
    tick();
    chk("ack_latency", cam_ack, 1'b1);
    cam_req = 1'b0;
    tick();
    chk("ack_one_cycle", cam_ack, 1'b0);
    cam_req = 1'b1; cam_pw = 20'd1000; ack_q.push_back(MIN); ack_q.push_back(MIN);
    tick();
    chk("held_ack1", cam_ack, 1'b1);
    tick();
    chk("held_gap", cam_ack, 1'b0);
    tick();
    chk("held_ack2", cam_ack, 1'b1);
    cam_req = 1'b0;
    tick();
    chk("held_done", cam_ack, 1'b0);
    tgt_m = MIN;
    // watchdog: fallback on the 50th silent strobe
    for (int i = 0; i < 49; i++) strobe(3);
    chk("wd_before", status, 4'd2);
    strobe(3);
    tgt_m = NEU;
    chk("wd_status", status, 4'd4);
    chk("wd_target", target, NEU);
    cam_req = 1'b1; cam_pw = 20'd60000; ack_q.push_back(20'd60000);
    tick();
    chk("timeout_ack", cam_ack, 1'b1);
    cam_req = 1'b0;
    tgt_m = 20'd60000;
    tick();
    chk("timeout_recover", status, 4'd2);
    // reset in the middle of a slew
    chk("busy_mid_slew", busy, pw_m != tgt_m);
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    pw_m = NEU; tgt_m = NEU;
    chk("mid_rst_pw_out", pw_out, NEU);
    chk("mid_rst_target", target, NEU);
    chk("mid_rst_status", status, 4'd0);
    tick(5);
    strobe(3);
    chk("post_rst_cam", status, 4'd2);
    // strobe and accept in the same cycle: the slew uses the old target
    period_start = 1'b1; cam_req = 1'b1; cam_pw = 20'd60000;
    pw_m = step(pw_m, tgt_m);
    load_q.push_back(pw_m);
    ack_q.push_back(20'd60000);
    tick();
    period_start = 1'b0; cam_req = 1'b0;
    tgt_m = 20'd60000;
    chk("same_cycle_pw_out", pw_out, NEU);
    tick(3);
    strobe(3);
    chk("next_strobe_pw_out", pw_out, 20'd56686);
    // jog presses with wrap
    sw = 2'b11;
    tick(2);
    chk("jog_status", status, 4'd3);
    chk("jog_start", target, NEU);
    jm = NEU;
    for (int i = 1; i <= 310; i++) begin
      push = 1'b0;
      tick(10);
      push = 1'b1;
      tick(10);
      jm = (jm > MAX - STEP) ? MIN : jm + STEP;
      chk($sformatf("jog_target_%0d", i), target, jm);
    end
    chk("jog_final", target, 20'd18012);
    // sw change beats a simultaneous request
    sw = 2'b00;
    tick(2);
    chk("cam_keeps_target", target, 20'd18012);
    sw = 2'b01; cam_req = 1'b1; cam_pw = 20'd30000;
    tick();
    chk("mode_wins_ack", cam_ack, 1'b0);
    chk("mode_wins_status", status, 4'd1);
    cam_req = 1'b0;
    tick(2);
    chk("mode_wins_target", target, MAX);
    tick(5);
    chk("load_q_drained", load_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
